// File: rtl/window_stream_gen_pkg.sv
// ---------------------------------------------------------------------------
// window_pkg : shared constants and FSM encoding for window_stream_gen
// Revision   : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package window_pkg;

  localparam logic [1:0] MODE_ZERO   = 2'd0;
  localparam logic [1:0] MODE_CLAMP  = 2'd1;
  localparam logic [1:0] MODE_MIRROR = 2'd2;

  localparam int DEFAULT_MAX_K = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/window_stream_gen_if.sv
// ---------------------------------------------------------------------------
// window_stream_if : address/flag beat stream with valid/ready handshake
// Revision         : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface window_stream_if #(
  parameter int ADDR_W = 32
);

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] addr;
  logic              in_bounds;
  logic              col_last;
  logic              row_last;
  logic              frame_last;

  modport master (
    output out_valid, addr, in_bounds, col_last, row_last, frame_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, addr, in_bounds, col_last, row_last, frame_last,
    output out_ready
  );

endinterface

`default_nettype wire

// File: rtl/window_stream_gen_boundary_map.sv
// ---------------------------------------------------------------------------
// boundary_map : folds a signed coordinate into [0, dim-1] per boundary mode
// Revision     : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module boundary_map
  import window_pkg::*;
#(
  parameter int DIM_W = 16,
  parameter int CW    = DIM_W + 2
) (
  input  logic signed [CW-1:0]    coord,
  input  logic        [DIM_W-1:0] dim,
  input  logic        [1:0]       mode,
  output logic        [DIM_W-1:0] mapped,
  output logic                    in_range
);

  // One extra bit keeps 2*dim-2-coord free of overflow.
  localparam int IW = CW + 1;
  localparam logic signed [IW-1:0] TWO = IW'(2);

  logic signed [IW-1:0] c;
  logic signed [IW-1:0] d;
  logic signed [IW-1:0] t;

  always_comb begin
    c        = {coord[CW-1], coord};
    d        = {{(IW-DIM_W){1'b0}}, dim};
    in_range = !c[IW-1] && (c < d);

    case (mode)
      MODE_CLAMP:  t = c;
      MODE_MIRROR: begin
        if (c[IW-1])    t = -c;
        else if (c >= d) t = d + d - TWO - c;
        else             t = c;
      end
      default:     t = in_range ? c : '0;
    endcase

    // Final clamp also absorbs mirror overshoot when dim == 1 or k >= dim.
    if (t[IW-1])     mapped = '0;
    else if (t >= d) mapped = dim - DIM_W'(1);
    else             mapped = t[DIM_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/window_stream_gen.sv
// ---------------------------------------------------------------------------
// window_stream_gen : sliding-window read address streamer with boundary remap
// Revision          : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module window_stream_gen
  import window_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16,
  parameter int MAX_K  = DEFAULT_MAX_K,
  localparam int K_BITS = $clog2(MAX_K + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] h,
  input  logic [ADDR_W-1:0] w,
  input  logic [K_BITS-1:0] kx,
  input  logic [K_BITS-1:0] ky,
  input  logic [1:0]        mode,
  window_stream_if.master   stream,
  output logic              busy,
  output logic              done
);

  localparam int CW = DIM_W + 2;
  localparam int XW = DIM_W + 1;
  localparam logic [K_BITS-1:0] K_MAX = K_BITS'(MAX_K);

  state_t              state;
  logic                valid;
  logic [DIM_W-1:0]    cfg_h;
  logic [ADDR_W-1:0]   cfg_w;
  logic [K_BITS-1:0]   cfg_kx;
  logic [K_BITS-1:0]   cfg_ky;
  logic [1:0]          cfg_mode;
  logic [DIM_W-1:0]    cy;
  logic [XW-1:0]       x;
  logic signed [K_BITS:0] dy;

  logic [K_BITS-1:0]   kx_sat;
  logic [K_BITS-1:0]   ky_sat;
  logic [XW-1:0]       x_end;
  logic                col_last;
  logic                x_last;
  logic                cy_last;
  logic                fire;
  logic signed [CW-1:0] yr;
  logic signed [CW-1:0] xr;
  logic [DIM_W-1:0]    yc;
  logic [DIM_W-1:0]    xc;
  logic                y_in;
  logic                x_in;
  logic [ADDR_W-1:0]   addr_lin;

  always_comb begin
    kx_sat   = (kx > K_MAX) ? K_MAX : kx;
    ky_sat   = (ky > K_MAX) ? K_MAX : ky;
    x_end    = XW'(cfg_w[DIM_W-1:0]) + XW'(cfg_kx) - XW'(1);
    col_last = (dy == $signed({1'b0, cfg_ky}));
    x_last   = (x == x_end);
    cy_last  = (cy == cfg_h - DIM_W'(1));
    fire     = valid && stream.out_ready;
    yr       = $signed({2'b00, cy}) + CW'(dy);
    xr       = $signed({1'b0, x});
    addr_lin = ADDR_W'(yc) * cfg_w + ADDR_W'(xc);
  end

  boundary_map #(.DIM_W(DIM_W)) u_map_y (
    .coord    (yr),
    .dim      (cfg_h),
    .mode     (cfg_mode),
    .mapped   (yc),
    .in_range (y_in)
  );

  boundary_map #(.DIM_W(DIM_W)) u_map_x (
    .coord    (xr),
    .dim      (cfg_w[DIM_W-1:0]),
    .mode     (cfg_mode),
    .mapped   (xc),
    .in_range (x_in)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_h    <= '0;
      cfg_w    <= '0;
      cfg_kx   <= '0;
      cfg_ky   <= '0;
      cfg_mode <= MODE_ZERO;
      cy       <= '0;
      x        <= '0;
      dy       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cfg_h    <= h[DIM_W-1:0];
            cfg_w    <= w;
            cfg_kx   <= kx_sat;
            cfg_ky   <= ky_sat;
            cfg_mode <= (mode == MODE_CLAMP || mode == MODE_MIRROR) ? mode : MODE_ZERO;
            cy       <= '0;
            x        <= '0;
            dy       <= -$signed({1'b0, ky_sat});
            if (h == '0 || w == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              valid <= 1'b1;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (fire) begin
            if (col_last) begin
              dy <= -$signed({1'b0, cfg_ky});
              if (x_last) begin
                x <= '0;
                if (cy_last) begin
                  cy    <= '0;
                  state <= DONE;
                  valid <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  cy <= cy + DIM_W'(1);
                end
              end else begin
                x <= x + XW'(1);
              end
            end else begin
              dy <= dy + (K_BITS+1)'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign stream.out_valid  = valid;
  assign stream.in_bounds  = valid && x_in && y_in;
  assign stream.col_last   = valid && col_last;
  assign stream.row_last   = valid && col_last && x_last;
  assign stream.frame_last = valid && col_last && x_last && cy_last;
  // Out-of-image taps read address 0 in zero mode; the sorter masks them via in_bounds.
  assign stream.addr = (valid && ((x_in && y_in) || cfg_mode != MODE_ZERO)) ? addr_lin : '0;

endmodule

`default_nettype wire

// File: tb/tb_window_stream_gen.sv
// ---------------------------------------------------------------------------
// tb_window_stream_gen : directed + randomized check against a window model
// Revision             : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_window_stream_gen;

  localparam int ADDR_W = 32;
  localparam int MAX_K  = 12;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  flags;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] h = '0;
  logic [31:0] w = '0;
  logic [3:0]  kx = '0;
  logic [3:0]  ky = '0;
  logic [1:0]  mode = '0;
  logic        busy;
  logic        done;

  int nvec = 0;
  int nbad = 0;

  beat_t       exp_q[$];
  logic [31:0] got_addr[$];
  logic        got_ib[$];
  logic [31:0] ref_addr[$];

  window_stream_if #(.ADDR_W(ADDR_W)) sif ();

  window_stream_gen #(.ADDR_W(ADDR_W), .DIM_W(16), .MAX_K(MAX_K)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .h      (h),
    .w      (w),
    .kx     (kx),
    .ky     (ky),
    .mode   (mode),
    .stream (sif.master),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nbad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int remap(input int c, input int d, input int md);
    int t;
    if (md == 1) t = c;
    else if (md == 2) t = (c < 0) ? -c : ((c >= d) ? 2*d - 2 - c : c);
    else t = (c >= 0 && c < d) ? c : 0;
    if (t < 0) t = 0;
    if (t > d - 1) t = d - 1;
    return t;
  endfunction

  // Enumerate the frame straight from the scan-order rules.
  task automatic build_model(input int hh, input int ww, input int kxx, input int kyy, input int md);
    int ke, kv, yr, ib, a;
    beat_t b;
    ke = (kxx > MAX_K) ? MAX_K : kxx;
    kv = (kyy > MAX_K) ? MAX_K : kyy;
    exp_q.delete();
    for (int cy = 0; cy < hh; cy++)
      for (int xx = 0; xx < ww + ke; xx++)
        for (int dv = -kv; dv <= kv; dv++) begin
          yr = cy + dv;
          ib = (yr >= 0 && yr < hh && xx < ww) ? 1 : 0;
          if (md == 1 || md == 2) a = remap(yr, hh, md) * ww + remap(xx, ww, md);
          else a = ib ? yr * ww + xx : 0;
          b.addr  = 32'(a);
          b.flags = {ib[0], dv == kv, dv == kv && xx == ww - 1 + ke,
                     dv == kv && xx == ww - 1 + ke && cy == hh - 1};
          exp_q.push_back(b);
        end
  endtask

  task automatic run_frame(input int hh, input int ww, input int kxx, input int kyy,
                           input int md, input bit rnd, input bit inj);
    int n_exp, accepted, ke, kv;
    bit seen_done, stalled, rdy;
    logic [31:0] hold_a;
    logic [3:0]  hold_f;
    beat_t e;
    ke = (kxx > MAX_K) ? MAX_K : kxx;
    kv = (kyy > MAX_K) ? MAX_K : kyy;
    build_model(hh, ww, kxx, kyy, md);
    n_exp = exp_q.size();
    got_addr.delete();
    got_ib.delete();
    @(negedge clk);
    h = 32'(hh); w = 32'(ww); kx = 4'(kxx); ky = 4'(kyy); mode = 2'(md); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    h = $urandom; w = $urandom; kx = 4'($urandom); ky = 4'($urandom); mode = 2'($urandom);
    accepted = 0; seen_done = 1'b0; stalled = 1'b0; hold_a = '0; hold_f = '0;
    for (int cyc = 0; cyc < 20000 && !seen_done; cyc++) begin
      start = 1'b0;
      if (done) begin
        seen_done = 1'b1;
        chk("done_beats", 64'(accepted), 64'(hh * (ww + ke) * (2 * kv + 1)));
        chk("done_valid_low", {63'd0, sif.out_valid}, 64'd0);
      end else if (sif.out_valid) begin
        chk("busy_run", {63'd0, busy}, 64'd1);
        if (stalled) begin
          chk("stall_addr", {32'd0, sif.addr}, {32'd0, hold_a});
          chk("stall_flags", {60'd0, sif.in_bounds, sif.col_last, sif.row_last, sif.frame_last},
              {60'd0, hold_f});
        end
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        sif.out_ready = rdy;
        if (rdy) begin
          chk("no_overrun", {63'd0, accepted < n_exp}, 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("addr", {32'd0, sif.addr}, {32'd0, e.addr});
            chk("flags", {60'd0, sif.in_bounds, sif.col_last, sif.row_last, sif.frame_last},
                {60'd0, e.flags});
          end
          got_addr.push_back(sif.addr);
          got_ib.push_back(sif.in_bounds);
          accepted++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hold_a = sif.addr;
          hold_f = {sif.in_bounds, sif.col_last, sif.row_last, sif.frame_last};
        end
        if (inj && cyc == 5) begin
          start = 1'b1; h = 32'd1; w = 32'd1; kx = '0; ky = '0;
        end
      end else begin
        sif.out_ready = 1'($urandom_range(0, 1));
      end
      if (!seen_done) @(negedge clk);
    end
    chk("done_seen", {63'd0, seen_done}, 64'd1);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    sif.out_ready = 1'b0;
  endtask

  initial begin
    int rh, rw;
    sif.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", {63'd0, sif.out_valid}, 64'd0);
    chk("rst_addr", {32'd0, sif.addr}, 64'd0);
    chk("rst_flags", {60'd0, sif.in_bounds, sif.col_last, sif.row_last, sif.frame_last}, 64'd0);
    chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_valid", {63'd0, sif.out_valid}, 64'd0);

    // ZERO, 3x4, kx=ky=1
    run_frame(3, 4, 1, 1, 0, 1'b0, 1'b0);
    chk("zero_a0", {32'd0, got_addr[0]}, 64'd0);
    chk("zero_a1", {32'd0, got_addr[1]}, 64'd0);
    chk("zero_a2", {32'd0, got_addr[2]}, 64'd4);
    chk("zero_ib", {61'd0, got_ib[0], got_ib[1], got_ib[2]}, 64'b011);
    chk("zero_x4_addr", {got_addr[12], got_addr[14]}, 64'd0);
    chk("zero_x4_ib", {61'd0, got_ib[12], got_ib[13], got_ib[14]}, 64'd0);
    ref_addr = got_addr;

    // CLAMP
    run_frame(3, 4, 1, 1, 1, 1'b0, 1'b0);
    chk("clamp_col0", {got_addr[0][15:0], got_addr[1][15:0], got_addr[2][15:0]}, {16'd0, 16'd0, 16'd4});
    chk("clamp_col0_ib", {63'd0, got_ib[0]}, 64'd0);
    chk("clamp_last_col", {got_addr[42][15:0], got_addr[43][15:0], got_addr[44][15:0]},
        {16'd7, 16'd11, 16'd11});
    chk("clamp_last_ib", {61'd0, got_ib[42], got_ib[43], got_ib[44]}, 64'd0);

    // MIRROR
    run_frame(3, 4, 1, 1, 2, 1'b0, 1'b0);
    chk("mirror_col0", {got_addr[0][15:0], got_addr[1][15:0], got_addr[2][15:0]}, {16'd4, 16'd0, 16'd4});
    chk("mirror_x4", {got_addr[12][15:0], got_addr[13][15:0], got_addr[14][15:0]}, {16'd6, 16'd2, 16'd6});

    // Backpressure on the ZERO case, with a start pulse injected mid-frame
    run_frame(3, 4, 1, 1, 0, 1'b1, 1'b1);
    chk("bp_count", 64'(got_addr.size()), 64'd45);
    for (int i = 0; i < 45; i++)
      if (i < got_addr.size()) chk("bp_same_seq", {32'd0, got_addr[i]}, {32'd0, ref_addr[i]});

    // Asymmetric window
    run_frame(2, 2, 2, 0, 0, 1'b0, 1'b0);
    chk("asym_addrs", {got_addr[0][7:0], got_addr[1][7:0], got_addr[2][7:0], got_addr[3][7:0],
                       got_addr[4][7:0], got_addr[5][7:0], got_addr[6][7:0], got_addr[7][7:0]},
        {8'd0, 8'd1, 8'd0, 8'd0, 8'd2, 8'd3, 8'd0, 8'd0});

    // Degenerate h=0
    @(negedge clk);
    h = 32'd0; w = 32'd4; kx = 4'd1; ky = 4'd1; mode = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("h0_done", {62'd0, done, sif.out_valid}, 64'b10);
    @(negedge clk);
    chk("h0_done_pulse", {62'd0, done, sif.out_valid}, 64'b00);

    // Reset mid-frame
    sif.out_ready = 1'b1;
    h = 32'd3; w = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_valid_before", {63'd0, sif.out_valid}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, sif.out_valid}, 64'd0);
    chk("mid_rst_outs", {sif.addr, 28'd0, sif.in_bounds, sif.col_last, busy, done}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_stays_idle", {62'd0, sif.out_valid, busy}, 64'd0);
    sif.out_ready = 1'b0;

    // Randomized frames, including kx/ky saturation and mode 3
    for (int f = 0; f < 5; f++) begin
      rh = $urandom_range(1, 5);
      rw = $urandom_range(1, 6);
      run_frame(rh, rw, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

`default_nettype wire
